// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding, PC step and
// the reset/idle instruction word.
package fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'd0;

  // Fetch addresses are always word aligned, whatever a redirect asks for.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter register: redirect load has priority over increment;
// with neither asserted the PC holds.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_inc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= align_word(i_load_val);
    end else if (i_inc) begin
      r_pc <= r_pc + PC_INC;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request to instruction memory,
// stall buffering, branch redirect. Optional counters under FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PCWrite,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ready,
  input  logic [31:0] Imem_data,
  output logic [31:0] PC_out,
  output logic [31:0] PCAdder_out,
  output logic [31:0] Instruction_out,
  output logic        Fetch_valid,
  output logic        IFID_flush,
  output logic [1:0]  o_dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] Perf_fetched,
  output logic [31:0] Perf_stall
`endif
);

  // Memory handshake: Imem_req/Imem_addr stay asserted and stable in FETCH
  // until a cycle with Imem_ready=1; Imem_data is valid only in that cycle.
  // The memory keeps one accepted request in flight even if req drops (DRAIN).

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_fetch_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pcadd;
  logic [31:0] r_hold_buf;

  logic        w_in_fetch;
  logic        w_in_hold;
  logic        w_deliver;
  logic        w_capture;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;

  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_in_hold  = (r_state == ST_HOLD);
  assign w_deliver  = !Branch_taken && PCWrite &&
                      ((w_in_fetch && Imem_ready) || w_in_hold);
  assign w_capture  = !Branch_taken && !PCWrite && w_in_fetch && Imem_ready;
  assign w_pc_plus4 = w_pc + PC_INC;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk      (Clk),
    .i_rst_n    (Rst),
    .i_load     (Branch_taken),
    .i_load_val (Branch_target),
    .i_inc      (w_deliver),
    .o_pc       (w_pc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (Branch_taken) begin
          w_state_nxt = Imem_ready ? ST_FETCH : ST_DRAIN;
        end else if (w_capture) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD:  if (Branch_taken || PCWrite) w_state_nxt = ST_FETCH;
      ST_DRAIN: if (Imem_ready) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state       <= ST_IDLE;
      r_fetch_valid <= 1'b0;
      r_instr       <= INSTR_NOP;
      r_pcadd       <= 32'd0;
      r_hold_buf    <= INSTR_NOP;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_valid <= w_deliver;
      if (w_deliver) begin
        r_instr <= w_in_hold ? r_hold_buf : Imem_data;
        r_pcadd <= w_pc_plus4;
      end
      // Buffer is dropped once HOLD exits, whether released or redirected.
      if (w_capture) begin
        r_hold_buf <= Imem_data;
      end else if (w_in_hold && (Branch_taken || PCWrite)) begin
        r_hold_buf <= INSTR_NOP;
      end
    end
  end

  assign Imem_req        = w_in_fetch;
  assign Imem_addr       = w_pc;
  assign PC_out          = w_pc;
  assign PCAdder_out     = r_pcadd;
  assign Instruction_out = r_instr;
  assign Fetch_valid     = r_fetch_valid;
  assign IFID_flush      = Branch_taken;
  assign o_dbg_state     = r_state;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      if (r_fetch_valid && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if ((w_in_fetch || w_in_hold) && !w_deliver &&
          (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign Perf_fetched = r_perf_fetched;
  assign Perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked each
// cycle against a flag-based reference model and a delivery scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        PCWrite = 1'b1;
  logic        Branch_taken = 1'b0;
  logic [31:0] Branch_target = 32'd0;
  logic        Imem_ready = 1'b0;
  logic [31:0] Imem_data = 32'd0;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic [31:0] PC_out;
  logic [31:0] PCAdder_out;
  logic [31:0] Instruction_out;
  logic        Fetch_valid;
  logic        IFID_flush;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] Perf_fetched;
  logic [31:0] Perf_stall;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .PCWrite         (PCWrite),
    .Branch_taken    (Branch_taken),
    .Branch_target   (Branch_target),
    .Imem_req        (Imem_req),
    .Imem_addr       (Imem_addr),
    .Imem_ready      (Imem_ready),
    .Imem_data       (Imem_data),
    .PC_out          (PC_out),
    .PCAdder_out     (PCAdder_out),
    .Instruction_out (Instruction_out),
    .Fetch_valid     (Fetch_valid),
    .IFID_flush      (IFID_flush),
    .o_dbg_state     (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .Perf_fetched    (Perf_fetched),
    .Perf_stall      (Perf_stall)
`endif
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: where the fetch engine is, expressed as phase flags.
  bit          m_valid = 0;
  bit          m_idle = 1, m_hold = 0, m_drain = 0, m_pulse = 0;
  logic [31:0] m_pc = RST_PC, m_buf = 0, m_instr = 0, m_pcadd = 0;
  logic [63:0] exp_q[$];
  logic [31:0] seen_addr[$], seen_pcadd[$], seen_instr[$];

  // Memory model: accepts one request, answers after lat cycles.
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  int          lat = 0;
  logic [31:0] mem_addr = 0;
  bit          force_en = 0;
  logic [31:0] force_val = 0;
  logic [31:0] salt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return force_en ? force_val : ((a * 32'h9E37_79B1) ^ salt);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic pw, input logic br,
                      input logic [31:0] tgt, input logic inj);
    bit          fetching, active, deliver;
    logic [31:0] dval;
    logic [63:0] exp_d;
    @(negedge Clk);
    Imem_ready = 1'b0;
    Imem_data  = $urandom;
    if (!mem_busy && Imem_req === 1'b1) begin
      mem_busy = 1;
      mem_addr = Imem_addr;
      mem_cnt  = lat;
      seen_addr.push_back(Imem_addr);
    end
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        Imem_ready = 1'b1;
        Imem_data  = mem_word(mem_addr);
      end else begin
        mem_cnt--;
      end
    end
    if (inj) begin
      Imem_ready = 1'b1;
      Imem_data  = $urandom;
    end
    Rst = rst; PCWrite = pw; Branch_taken = br; Branch_target = tgt;
    #1;
    fetching = !m_idle && !m_hold && !m_drain;
    if (m_valid) begin
      check32("imem_req", 32'(Imem_req), 32'(fetching));
      check32("imem_addr", Imem_addr, m_pc);
      check32("pc_out", PC_out, m_pc);
      check32("fetch_valid", 32'(Fetch_valid), 32'(m_pulse));
      check32("instr_out", Instruction_out, m_instr);
      check32("pcadder_out", PCAdder_out, m_pcadd);
      check32("ifid_flush", 32'(IFID_flush), 32'(br));
`ifdef FETCH_PERF_EN
      check32("perf_fetched", Perf_fetched, m_fetched);
      check32("perf_stall", Perf_stall, m_stall);
`endif
      if (Fetch_valid === 1'b1) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
        check64("scoreboard", {PCAdder_out, Instruction_out}, exp_d);
        seen_pcadd.push_back(PCAdder_out);
        seen_instr.push_back(Instruction_out);
      end
    end
    @(posedge Clk);
    if (!rst) begin
      m_idle = 1; m_hold = 0; m_drain = 0; m_pulse = 0;
      m_pc = RST_PC; m_buf = 0; m_instr = 0; m_pcadd = 0;
      exp_q.delete();
      mem_busy = 0;
`ifdef FETCH_PERF_EN
      m_fetched = 0; m_stall = 0;
`endif
    end else begin
      deliver = 0;
      dval    = 0;
      active  = fetching || m_hold;
      if (m_idle) begin
        m_idle = 0;
        if (br) m_pc = tgt & 32'hFFFF_FFFC;
      end else if (m_hold) begin
        if (br) begin
          m_pc = tgt & 32'hFFFF_FFFC; m_hold = 0;
        end else if (pw) begin
          deliver = 1; dval = m_buf; m_hold = 0;
        end
      end else if (m_drain) begin
        if (br) m_pc = tgt & 32'hFFFF_FFFC;
        if (Imem_ready) m_drain = 0;
      end else begin
        if (br) begin
          m_pc = tgt & 32'hFFFF_FFFC;
          if (!Imem_ready) m_drain = 1;
        end else if (Imem_ready) begin
          if (pw) begin
            deliver = 1; dval = Imem_data;
          end else begin
            m_hold = 1; m_buf = Imem_data;
          end
        end
      end
`ifdef FETCH_PERF_EN
      if (m_pulse && m_fetched != 32'hFFFF_FFFF) m_fetched++;
      if (active && !deliver && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
      m_pulse = deliver;
      if (deliver) begin
        m_instr = dval;
        m_pcadd = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        exp_q.push_back({m_pcadd, m_instr});
      end
      if (Imem_ready && mem_busy && mem_cnt == 0) mem_busy = 0;
    end
    m_valid = 1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    seen_addr.delete(); seen_pcadd.delete(); seen_instr.delete();
  endtask

  logic [31:0] x_pc;
  logic [31:0] exp_w;

  initial begin
    salt = $urandom;

    // Reset and zero-wait streaming.
    lat = 0;
    do_reset();
    check32("rst_instr", Instruction_out, 32'd0);
    check32("rst_pcadd", PCAdder_out, 32'd0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check32("zw_addr0", seen_addr.size() > 0 ? seen_addr[0] : 32'hxxxx_xxxx, 32'd0);
    check32("zw_addr1", seen_addr.size() > 1 ? seen_addr[1] : 32'hxxxx_xxxx, 32'd4);
    check32("zw_addr2", seen_addr.size() > 2 ? seen_addr[2] : 32'hxxxx_xxxx, 32'd8);
    check32("zw_pcadd0", seen_pcadd.size() > 0 ? seen_pcadd[0] : 32'hxxxx_xxxx, 32'd4);
    check32("zw_pcadd1", seen_pcadd.size() > 1 ? seen_pcadd[1] : 32'hxxxx_xxxx, 32'd8);
    check32("zw_pcadd2", seen_pcadd.size() > 2 ? seen_pcadd[2] : 32'hxxxx_xxxx, 32'd12);

    // Three-cycle memory latency.
    lat = 3;
    do_reset();
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check32("lat3_pulses", 32'(seen_pcadd.size()), 32'd1);
    check32("lat3_reqs", 32'(seen_addr.size()), 32'd2);
    exp_w = mem_word(32'd0);
    check32("lat3_data", seen_instr.size() > 0 ? seen_instr[0] : 32'hxxxx_xxxx, exp_w);

    // Stall with PCWrite=0 while the response returns.
    lat = 1;
    do_reset();
    force_en = 1; force_val = 32'h1234_5678;
    x_pc = m_pc;
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check32("hold_no_pulse", 32'(seen_pcadd.size()), 32'd0);
    check32("hold_no_req", 32'(seen_addr.size()), 32'd1);
    force_en = 0;
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check32("hold_instr", seen_instr.size() > 0 ? seen_instr[0] : 32'hxxxx_xxxx, 32'h1234_5678);
    check32("hold_resume", seen_addr.size() > 1 ? seen_addr[1] : 32'hxxxx_xxxx, x_pc + 32'd4);

    // Branch while a request is outstanding.
    lat = 3;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check32("br_no_pulse", 32'(seen_pcadd.size()), 32'd0);
    check32("br_new_addr", seen_addr.size() > 1 ? seen_addr[1] : 32'hxxxx_xxxx, 32'h0000_0100);

    // PC wrap at the top of the address space.
    lat = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check32("wrap_addr", seen_addr.size() > 1 ? seen_addr[1] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    check32("wrap_next", seen_addr.size() > 2 ? seen_addr[2] : 32'hxxxx_xxxx, 32'd0);
    check32("wrap_pcadd", seen_pcadd.size() > 0 ? seen_pcadd[0] : 32'hxxxx_xxxx, 32'd0);

    // Reset in the middle of a wait; late response lands in IDLE.
    lat = 0;
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    lat = 3;
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check32("mid_rst_instr", Instruction_out, 32'd0);
    check32("mid_rst_pcadd", PCAdder_out, 32'd0);
    seen_addr.delete();
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check32("mid_rst_addr", seen_addr.size() > 0 ? seen_addr[0] : 32'hxxxx_xxxx, RST_PC);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_pw, r_br;
      logic [31:0] r_tgt;
      lat   = $urandom_range(0, 3);
      r_rst = ($urandom_range(0, 99) != 0);
      r_pw  = ($urandom_range(0, 3) != 0);
      r_br  = ($urandom_range(0, 9) == 0);
      r_tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      step(r_rst, r_pw, r_br, r_tgt, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
